// File: rtl/audio_pkg.sv
// audio_pkg: shared widths and helpers for the audio level meter and the
// display logic that consumes its 4-bit level.
//   mag_to_level    : 16-bit magnitude -> 4-bit level (0..15)
//   level_to_thermo : 4-bit level -> 16-bit thermometer code, bits [lvl-1:0] set
package audio_pkg;

  localparam int             AUDIO_W   = 16;
  localparam int             LEVEL_W   = 4;
  localparam logic [LEVEL_W-1:0] LEVEL_MAX = 4'd15;

  // Full-scale magnitude (16'h8000) has bit 15 set and saturates to the top
  // level; everything below uses the next four bits as a linear step.
  function automatic logic [LEVEL_W-1:0] mag_to_level(input logic [AUDIO_W-1:0] mag);
    logic [LEVEL_W-1:0] lvl;
    if (mag[15]) lvl = LEVEL_MAX;
    else         lvl = mag[14:11];
    return lvl;
  endfunction

  function automatic logic [AUDIO_W-1:0] level_to_thermo(input logic [LEVEL_W-1:0] lvl);
    logic [AUDIO_W:0] one_hot;
    one_hot = 17'(1) << lvl;
    return one_hot[AUDIO_W-1:0] - 16'd1;
  endfunction

endpackage

// File: rtl/peak_hold_decay.sv
// peak_hold_decay: holds the displayed level with timed single-step decay and
// stretches the clip indicator over several windows.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   close_i        : one-cycle window-close strobe
//   new_level_i    : level of the window being closed
//   wclip_i        : window being closed contained a clipping sample
//   level_o        : held/decayed level
//   led_bar_o      : thermometer code of level_o
//   clip_o         : clip indicator
module peak_hold_decay
  import audio_pkg::*;
#(
  parameter int DECAY_WINDOWS = 8,
  parameter int CLIP_HOLD     = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               close_i,
  input  logic [LEVEL_W-1:0] new_level_i,
  input  logic               wclip_i,
  output logic [LEVEL_W-1:0] level_o,
  output logic [AUDIO_W-1:0] led_bar_o,
  output logic               clip_o
);

  // +1 keeps the widths non-zero when either parameter is 1.
  localparam int DCW = $clog2(DECAY_WINDOWS + 1);
  localparam int CCW = $clog2(CLIP_HOLD + 1);

  logic [LEVEL_W-1:0] held_q, held_d;
  logic [DCW-1:0]     decay_cnt_q, decay_cnt_d;
  logic [CCW-1:0]     clip_cnt_q, clip_cnt_d;
  logic               clip_q, clip_d;
  logic [AUDIO_W-1:0] led_bar_q;

  always_comb begin
    held_d      = held_q;
    decay_cnt_d = decay_cnt_q;
    clip_cnt_d  = clip_cnt_q;
    clip_d      = clip_q;
    if (close_i) begin
      // A louder (or equal) window restarts the decay period; otherwise the
      // held level drops one step every DECAY_WINDOWS quiet windows. new < held
      // in the decrement branch, so held is at least 1 there.
      if (new_level_i >= held_q) begin
        held_d      = new_level_i;
        decay_cnt_d = '0;
      end else if (decay_cnt_q == DCW'(DECAY_WINDOWS - 1)) begin
        held_d      = held_q - 4'd1;
        decay_cnt_d = '0;
      end else begin
        decay_cnt_d = decay_cnt_q + 1'b1;
      end

      if (wclip_i) begin
        clip_d     = 1'b1;
        clip_cnt_d = CCW'(CLIP_HOLD - 1);
      end else if (clip_cnt_q != '0) begin
        clip_cnt_d = clip_cnt_q - 1'b1;
      end else begin
        clip_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      held_q      <= '0;
      decay_cnt_q <= '0;
      clip_cnt_q  <= '0;
      clip_q      <= 1'b0;
      led_bar_q   <= '0;
    end else begin
      held_q      <= held_d;
      decay_cnt_q <= decay_cnt_d;
      clip_cnt_q  <= clip_cnt_d;
      clip_q      <= clip_d;
      // held_d equals held_q outside a close, so this only changes at a close.
      led_bar_q   <= level_to_thermo(held_d);
    end
  end

  assign level_o   = held_q;
  assign led_bar_o = led_bar_q;
  assign clip_o    = clip_q;

endmodule

// File: rtl/audio_level_meter.sv
// audio_level_meter: windowed peak meter for an unsigned 16-bit sample stream.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   sample_valid : audio_in accepted this cycle
//   audio_in     : unsigned sample, MIDPOINT is silence
//   level        : held/decayed peak level 0..15
//   level_valid  : one-cycle pulse when level updates at a window close
//   led_bar      : thermometer code of level
//   clip         : clip indicator, stretched over CLIP_HOLD windows
// Pipeline: stage 1 registers the magnitude and a last-of-window flag; stage 2
// folds it into the running peak and, on the last sample, closes the window.
module audio_level_meter
  import audio_pkg::*;
#(
  parameter logic [AUDIO_W-1:0] MIDPOINT       = 16'h8000,
  parameter int                 WINDOW_SAMPLES = 1024,
  parameter int                 DECAY_WINDOWS  = 8,
  parameter logic [AUDIO_W-1:0] CLIP_THRESH    = 16'h7F00,
  parameter int                 CLIP_HOLD      = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sample_valid,
  input  logic [AUDIO_W-1:0] audio_in,
  output logic [LEVEL_W-1:0] level,
  output logic               level_valid,
  output logic [AUDIO_W-1:0] led_bar,
  output logic               clip
);

  localparam int WCW = $clog2(WINDOW_SAMPLES);

  // Stage 1
  logic [WCW-1:0]     win_cnt_q, win_cnt_d;
  logic [AUDIO_W-1:0] mag_q, mag_d;
  logic               s1_valid_q, s1_last_q, s1_last_d;

  // Stage 2
  logic [AUDIO_W-1:0] peak_q, pk;
  logic               win_clip_q, wclip;
  logic               level_valid_q;
  logic               close;

  // Exact |audio_in - MIDPOINT|; the subtraction order avoids wraparound.
  always_comb begin
    if (audio_in >= MIDPOINT) mag_d = audio_in - MIDPOINT;
    else                      mag_d = MIDPOINT - audio_in;
    s1_last_d = (win_cnt_q == WCW'(WINDOW_SAMPLES - 1));
    win_cnt_d = s1_last_d ? '0 : win_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      win_cnt_q  <= '0;
      mag_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
    end else begin
      s1_valid_q <= sample_valid;
      if (sample_valid) begin
        win_cnt_q <= win_cnt_d;
        mag_q     <= mag_d;
        s1_last_q <= s1_last_d;
      end
    end
  end

  assign pk    = (mag_q > peak_q) ? mag_q : peak_q;
  assign wclip = win_clip_q | (mag_q >= CLIP_THRESH);
  assign close = s1_valid_q & s1_last_q;

  // On a close the accumulators clear so the next window's first sample,
  // arriving in stage 2 one edge later, starts from zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      peak_q        <= '0;
      win_clip_q    <= 1'b0;
      level_valid_q <= 1'b0;
    end else begin
      level_valid_q <= close;
      if (s1_valid_q) begin
        if (s1_last_q) begin
          peak_q     <= '0;
          win_clip_q <= 1'b0;
        end else begin
          peak_q     <= pk;
          win_clip_q <= wclip;
        end
      end
    end
  end

  peak_hold_decay #(
    .DECAY_WINDOWS(DECAY_WINDOWS),
    .CLIP_HOLD    (CLIP_HOLD)
  ) u_hold (
    .clk        (clk),
    .reset      (reset),
    .close_i    (close),
    .new_level_i(mag_to_level(pk)),
    .wclip_i    (wclip),
    .level_o    (level),
    .led_bar_o  (led_bar),
    .clip_o     (clip)
  );

  assign level_valid = level_valid_q;

endmodule

// File: tb/tb_audio_level_meter.sv
module tb_audio_level_meter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sample_valid = 1'b0;
  logic [15:0] audio_in = 16'h0000;
  logic [3:0]  level;
  logic        level_valid;
  logic [15:0] led_bar;
  logic        clip;

  int total = 0;
  int bad   = 0;
  int pulses = 0;

  always #5 clk = ~clk;

  audio_level_meter #(
    .MIDPOINT      (16'h8000),
    .WINDOW_SAMPLES(4),
    .DECAY_WINDOWS (2),
    .CLIP_THRESH   (16'h7F00),
    .CLIP_HOLD     (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sample_valid(sample_valid),
    .audio_in    (audio_in),
    .level       (level),
    .level_valid (level_valid),
    .led_bar     (led_bar),
    .clip        (clip)
  );

  always @(posedge clk) if (level_valid === 1'b1) pulses <= pulses + 1;

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    sample_valid = 1'b0;
    repeat (cycles) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Drives four accepted samples; with gaps, idle cycles carry junk audio_in.
  // Returns at 1ns after the edge accepting the last sample.
  task automatic feed4(input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] c, input logic [15:0] d, input bit gaps);
    logic [15:0] s [4];
    s[0] = a; s[1] = b; s[2] = c; s[3] = d;
    for (int i = 0; i < 4; i++) begin
      sample_valid = 1'b1;
      audio_in = s[i];
      @(posedge clk); #1;
      sample_valid = 1'b0;
      if (gaps && i < 3) begin
        repeat ($urandom_range(1, 5)) begin
          audio_in = (($urandom & 1) != 0) ? 16'hFFFF : 16'h0000;
          @(posedge clk); #1;
        end
      end
    end
  endtask

  task automatic test_reset;
    do_reset(3);
    total++;
    if (level !== 4'd0 || level_valid !== 1'b0 || led_bar !== 16'h0 || clip !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: level=%0d lv=%b led=%h clip=%b required 0/0/0000/0",
               level, level_valid, led_bar, clip);
    end
    feed4(16'h8000, 16'h8000, 16'h8000, 16'h8000, 1'b0);
    total++;
    if (level_valid !== 1'b0) begin
      bad++; $display("FAIL silent_early_pulse: level_valid=%b required 0", level_valid);
    end
    @(posedge clk); #1;
    total++;
    if (level_valid !== 1'b1 || level !== 4'd0 || led_bar !== 16'h0 || clip !== 1'b0) begin
      bad++;
      $display("FAIL silent_window: lv=%b level=%0d led=%h clip=%b required 1/0/0000/0",
               level_valid, level, led_bar, clip);
    end
    $display("silent window: level=%0d led=%h clip=%b", level, led_bar, clip);
    @(posedge clk); #1;
    total++;
    if (level_valid !== 1'b0) begin
      bad++; $display("FAIL pulse_width: level_valid=%b required 0", level_valid);
    end
  endtask

  task automatic test_level;
    feed4(16'h8000, 16'hA000, 16'h7000, 16'h8100, 1'b0);
    @(posedge clk); #1;
    total++;
    if (level_valid !== 1'b1 || level !== 4'd4 || led_bar !== 16'h000F || clip !== 1'b0) begin
      bad++;
      $display("FAIL level4_window: lv=%b level=%0d led=%h clip=%b required 1/4/000f/0",
               level_valid, level, led_bar, clip);
    end
    $display("level window: level=%0d led=%h", level, led_bar);
  endtask

  task automatic test_decay;
    logic [3:0] exp_lvl [9];
    exp_lvl[0] = 4; exp_lvl[1] = 3; exp_lvl[2] = 3; exp_lvl[3] = 2; exp_lvl[4] = 2;
    exp_lvl[5] = 1; exp_lvl[6] = 1; exp_lvl[7] = 0; exp_lvl[8] = 0;
    for (int w = 0; w < 9; w++) begin
      feed4(16'h8000, 16'h8001, 16'h7FFF, 16'h8000, 1'b0);
      @(posedge clk); #1;
      total++;
      if (level_valid !== 1'b1 || level !== exp_lvl[w]) begin
        bad++;
        $display("FAIL decay_w%0d: lv=%b level=%0d required 1/%0d", w, level_valid, level, exp_lvl[w]);
      end
      $display("decay window %0d: level=%0d led=%h", w, level, led_bar);
    end
  endtask

  task automatic test_clip;
    logic exp_clip [3];
    exp_clip[0] = 1'b1; exp_clip[1] = 1'b1; exp_clip[2] = 1'b0;
    feed4(16'h8000, 16'hFFFF, 16'h8000, 16'h8000, 1'b0);
    @(posedge clk); #1;
    total++;
    if (level_valid !== 1'b1 || clip !== 1'b1 || level !== 4'd15) begin
      bad++;
      $display("FAIL clip_window: lv=%b clip=%b level=%0d required 1/1/15", level_valid, clip, level);
    end
    for (int w = 0; w < 3; w++) begin
      feed4(16'h8000, 16'h8000, 16'h8000, 16'h8000, 1'b0);
      @(posedge clk); #1;
      total++;
      if (clip !== exp_clip[w]) begin
        bad++; $display("FAIL clip_hold_w%0d: clip=%b required %b", w, clip, exp_clip[w]);
      end
      $display("clip hold window %0d: clip=%b level=%0d", w, clip, level);
    end
    feed4(16'h8000, 16'h8000, 16'h0000, 16'h8000, 1'b0);
    @(posedge clk); #1;
    total++;
    if (level !== 4'd15 || led_bar !== 16'h7FFF || clip !== 1'b1) begin
      bad++;
      $display("FAIL full_scale: level=%0d led=%h clip=%b required 15/7fff/1", level, led_bar, clip);
    end
  endtask

  task automatic test_gaps;
    int p0;
    do_reset(2);
    p0 = pulses;
    feed4(16'h8000, 16'hA000, 16'h7000, 16'h8100, 1'b1);
    total++;
    if (pulses !== p0) begin
      bad++; $display("FAIL gaps_early: pulses=%0d required %0d", pulses - p0, 0);
    end
    @(posedge clk); #1;
    total++;
    if (level_valid !== 1'b1 || level !== 4'd4 || led_bar !== 16'h000F || clip !== 1'b0) begin
      bad++;
      $display("FAIL gaps_window: lv=%b level=%0d led=%h clip=%b required 1/4/000f/0",
               level_valid, level, led_bar, clip);
    end
    $display("gapped window: level=%0d led=%h clip=%b", level, led_bar, clip);
  endtask

  task automatic test_back_to_back;
    logic [15:0] s [8];
    s[0] = 16'h8000; s[1] = 16'h8000; s[2] = 16'h8000; s[3] = 16'hA000;
    s[4] = 16'hC000; s[5] = 16'h8000; s[6] = 16'h8000; s[7] = 16'h8000;
    do_reset(2);
    for (int i = 0; i < 8; i++) begin
      sample_valid = 1'b1;
      audio_in = s[i];
      @(posedge clk); #1;
      if (i == 4) begin
        total++;
        if (level_valid !== 1'b1 || level !== 4'd4) begin
          bad++; $display("FAIL b2b_first: lv=%b level=%0d required 1/4", level_valid, level);
        end
      end
      if (i == 5) begin
        total++;
        if (level_valid !== 1'b0) begin
          bad++; $display("FAIL b2b_pulse_width: lv=%b required 0", level_valid);
        end
      end
    end
    sample_valid = 1'b0;
    @(posedge clk); #1;
    total++;
    if (level_valid !== 1'b1 || level !== 4'd8 || led_bar !== 16'h00FF) begin
      bad++;
      $display("FAIL b2b_second: lv=%b level=%0d led=%h required 1/8/00ff", level_valid, level, led_bar);
    end
    $display("back-to-back second window: level=%0d led=%h", level, led_bar);
  endtask

  task automatic test_reset_mid_window;
    int p0;
    do_reset(2);
    feed4(16'hFFFF, 16'hFFFF, 16'h8000, 16'h8000, 1'b0);
    // The window above closed; now abort a partial one.
    @(posedge clk); #1;
    sample_valid = 1'b1; audio_in = 16'hFFFF;
    repeat (2) begin @(posedge clk); #1; end
    sample_valid = 1'b0;
    do_reset(2);
    p0 = pulses;
    feed4(16'h8000, 16'h9000, 16'h8800, 16'h8000, 1'b0);
    total++;
    if (pulses !== p0 || level_valid !== 1'b0) begin
      bad++; $display("FAIL abort_pulse: pulses=%0d lv=%b required 0/0", pulses - p0, level_valid);
    end
    @(posedge clk); #1;
    total++;
    if (level_valid !== 1'b1 || level !== 4'd2 || led_bar !== 16'h0003 || clip !== 1'b0) begin
      bad++;
      $display("FAIL after_abort: lv=%b level=%0d led=%h clip=%b required 1/2/0003/0",
               level_valid, level, led_bar, clip);
    end
    $display("after mid-window reset: level=%0d led=%h clip=%b", level, led_bar, clip);
  endtask

  initial begin
    test_reset();
    test_level();
    test_decay();
    test_clip();
    test_gaps();
    test_back_to_back();
    test_reset_mid_window();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
